// File: rtl/hazard_unit_pkg.sv
// ----------------------------------------------------------------------------
// hazard_unit_pkg
//   Shared types and constants for the pipeline hazard/control unit:
//   opcode/register typedefs, the MIPS opcodes the hazard logic decodes,
//   FSM state encodings and small opcode-classification helpers.
// ----------------------------------------------------------------------------
package hazard_unit_pkg;

    typedef logic [5:0] opcode_t;
    typedef logic [4:0] regbits_t;

    localparam opcode_t OP_RTYPE = 6'b000000;
    localparam opcode_t OP_BEQ   = 6'b000100;
    localparam opcode_t OP_BNE   = 6'b000101;
    localparam opcode_t OP_LW    = 6'b100011;
    localparam opcode_t OP_SW    = 6'b101011;
    localparam opcode_t OP_LL    = 6'b110000;
    localparam opcode_t OP_SC    = 6'b111000;

    // Control FSM encodings
    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_LOAD_STALL = 2'd1;
    localparam logic [1:0] ST_HALT       = 2'd2;

    // Instructions that read rt as a source operand (not just as a destination)
    function automatic logic uses_rt(input opcode_t op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_SW)    || (op == OP_SC);
    endfunction

    function automatic logic is_load(input opcode_t op);
        return (op == OP_LW) || (op == OP_LL);
    endfunction

endpackage

// File: rtl/hazard_unit_load_use.sv
// ----------------------------------------------------------------------------
// load_use_detect
//   Combinational load-use hazard detection between the instruction in EX
//   (a load) and the instruction in ID (a consumer of the loaded register).
//   Ports:
//     opcode_ex_i / rt_ex_i            : instruction in EX and its load destination
//     opcode_id_i / rs_id_i / rt_id_i  : instruction in ID and its source registers
//     load_use_o                       : ID must wait for the load result
// ----------------------------------------------------------------------------
module load_use_detect
    import hazard_unit_pkg::*;
(
    input  logic [5:0] opcode_ex_i,
    input  logic [4:0] rt_ex_i,
    input  logic [5:0] opcode_id_i,
    input  logic [4:0] rs_id_i,
    input  logic [4:0] rt_id_i,
    output logic       load_use_o
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (rt_ex_i == rs_id_i);
    // rt only matters when ID actually reads it; I-type ALU ops write rt.
    assign rt_hit = uses_rt(opcode_id_i) && (rt_ex_i == rt_id_i);

    // $zero never carries a real dependency.
    assign load_use_o = is_load(opcode_ex_i) && (rt_ex_i != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_unit.sv
// ----------------------------------------------------------------------------
// hazard_unit
//   Pipeline control for the 5-stage MIPS datapath. Detects load-use hazards,
//   data-cache waits, EX-resolved redirects and halt, and drives the PC enable
//   and per-latch enable/flush controls. Control outputs are combinational so
//   a hazard seen in a cycle gates the clock edge that ends that cycle.
//   Ports:
//     CLK, RST                       : clock, synchronous active-high reset
//     ihit, dhit                     : icache valid / dcache request complete
//     dmemREN_mem, dmemWEN_mem       : MEM-stage load/store request
//     opcode_ID_EX, rt_ID_EX         : instruction in EX (load destination)
//     opcode_IF_ID, rs_IF_ID, rt_IF_ID : instruction in ID
//     branch_taken, jump_EX          : redirect resolved in EX
//     halt_WB                        : HALT reached WB
//     pc_en, *_en, *_flush           : PC / pipeline latch controls
//     halt                           : sticky halted flag (registered)
//     stall_cycles                   : saturating count of PC-stalled cycles
// ----------------------------------------------------------------------------
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic                   dmemREN_mem,
    input  logic                   dmemWEN_mem,
    input  logic [5:0]             opcode_ID_EX,
    input  logic [4:0]             rt_ID_EX,
    input  logic [5:0]             opcode_IF_ID,
    input  logic [4:0]             rs_IF_ID,
    input  logic [4:0]             rt_IF_ID,
    input  logic                   branch_taken,
    input  logic                   jump_EX,
    input  logic                   halt_WB,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   exmem_en,
    output logic                   memwb_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   halt,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    // bub_cnt holds at most LOAD_BUBBLES-2
    localparam int BUB_W = (LOAD_BUBBLES > 2) ? $clog2(LOAD_BUBBLES) : 1;

    logic [1:0]             state_q, state_d;
    logic [BUB_W-1:0]       bub_q, bub_d;
    logic                   halt_q, halt_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic mem_busy;
    logic redirect;
    logic load_use;

    load_use_detect u_lud (
        .opcode_ex_i (opcode_ID_EX),
        .rt_ex_i     (rt_ID_EX),
        .opcode_id_i (opcode_IF_ID),
        .rs_id_i     (rs_IF_ID),
        .rt_id_i     (rt_IF_ID),
        .load_use_o  (load_use)
    );

    assign mem_busy = (dmemREN_mem || dmemWEN_mem) && !dhit;
    assign redirect = branch_taken || jump_EX;

    always_comb begin
        state_d    = state_q;
        bub_d      = bub_q;
        halt_d     = halt_q;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;

        if (RST) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (state_q == ST_HALT || halt_WB || mem_busy) begin
            // Halted, halting, or full freeze while the dcache is busy.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            if (state_q != ST_HALT && halt_WB) begin
                state_d = ST_HALT;
                halt_d  = 1'b1;
            end
        end else if (redirect) begin
            // Squash IF and ID; any pending load-use dies with its consumer.
            pc_en      = ihit;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = ST_RUN;
            bub_d      = '0;
        end else if (state_q == ST_LOAD_STALL || load_use) begin
            // Hold PC and IF/ID, inject a bubble into EX.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            if (state_q == ST_LOAD_STALL) begin
                if (bub_q == '0) state_d = ST_RUN;
                else             bub_d   = bub_q - 1'b1;
            end else if (LOAD_BUBBLES > 1) begin
                state_d = ST_LOAD_STALL;
                bub_d   = BUB_W'(LOAD_BUBBLES - 2);
            end
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end

        stall_d = stall_q;
        if (!pc_en && state_q != ST_HALT && stall_q != '1)
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RUN;
            bub_q   <= '0;
            halt_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            halt_q  <= halt_d;
            stall_q <= stall_d;
        end
    end

    assign halt         = halt_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_hazard_unit
//   Drives two hazard_unit instances (LOAD_BUBBLES=1/STALL_CNT_W=16 and
//   LOAD_BUBBLES=3/STALL_CNT_W=8) with shared directed and random stimulus and
//   compares every output each cycle against a behavioural model that tracks
//   "bubbles still owed", a halted flag and an integer stall count.
// ----------------------------------------------------------------------------
module tb_hazard_unit;

    localparam logic [5:0] RTYPE = 6'b000000, BEQ = 6'b000100, BNE = 6'b000101,
                           LW = 6'b100011, SW = 6'b101011, LL = 6'b110000,
                           SC = 6'b111000, ADDI = 6'b001000;

    logic       CLK, RST, ihit, dhit, ren, wen, branch, jump, halt_wb;
    logic [5:0] op_ex, op_id;
    logic [4:0] rt_ex, rs_id, rt_id;

    logic        a_pc, a_ife, a_ide, a_exe, a_mwe, a_iff, a_idf, a_halt;
    logic [15:0] a_stall;
    logic        b_pc, b_ife, b_ide, b_exe, b_mwe, b_iff, b_idf, b_halt;
    logic [7:0]  b_stall;

    int checks = 0;
    int errors = 0;

    // reference model state
    int  a_pend, b_pend, a_cnt, b_cnt;
    bit  a_hlt, b_hlt, known;
    int  b_bubbles;

    hazard_unit #(.LOAD_BUBBLES(1), .STALL_CNT_W(16)) u_a (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dmemREN_mem(ren), .dmemWEN_mem(wen),
        .opcode_ID_EX(op_ex), .rt_ID_EX(rt_ex),
        .opcode_IF_ID(op_id), .rs_IF_ID(rs_id), .rt_IF_ID(rt_id),
        .branch_taken(branch), .jump_EX(jump), .halt_WB(halt_wb),
        .pc_en(a_pc), .ifid_en(a_ife), .idex_en(a_ide), .exmem_en(a_exe),
        .memwb_en(a_mwe), .ifid_flush(a_iff), .idex_flush(a_idf),
        .halt(a_halt), .stall_cycles(a_stall)
    );

    hazard_unit #(.LOAD_BUBBLES(3), .STALL_CNT_W(8)) u_b (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dmemREN_mem(ren), .dmemWEN_mem(wen),
        .opcode_ID_EX(op_ex), .rt_ID_EX(rt_ex),
        .opcode_IF_ID(op_id), .rs_IF_ID(rs_id), .rt_IF_ID(rt_id),
        .branch_taken(branch), .jump_EX(jump), .halt_WB(halt_wb),
        .pc_en(b_pc), .ifid_en(b_ife), .idex_en(b_ide), .exmem_en(b_exe),
        .memwb_en(b_mwe), .ifid_flush(b_iff), .idex_flush(b_idf),
        .halt(b_halt), .stall_cycles(b_stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) if (!RST && b_idf) b_bubbles <= b_bubbles + 1;

    function automatic bit lu_model();
        bit ld  = (op_ex == LW) || (op_ex == LL);
        bit urt = (op_id == RTYPE) || (op_id == BEQ) || (op_id == BNE) ||
                  (op_id == SW) || (op_id == SC);
        return ld && rt_ex != 0 && (rt_ex == rs_id || (urt && rt_ex == rt_id));
    endfunction

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
    function automatic logic [6:0] exp_ctl(input int pend, input bit hlt);
        if (RST)                         return 7'b0000011;
        if (hlt || halt_wb)              return 7'b0000000;
        if ((ren || wen) && !dhit)       return 7'b0000000;
        if (branch || jump)              return {ihit, 6'b111111};
        if (pend > 0 || lu_model())      return 7'b0011101;
        if (!ihit)                       return 7'b0111110;
        return 7'b1111100;
    endfunction

    task automatic advance(input int lb, input int maxc, input logic [6:0] e,
                           inout int pend, inout bit hlt, inout int cnt);
        if (RST) begin
            pend = 0; hlt = 0; cnt = 0;
        end else begin
            if (!e[6] && !hlt && cnt < maxc) cnt++;
            if (hlt) ;
            else if (halt_wb) hlt = 1;
            else if ((ren || wen) && !dhit) ;
            else if (branch || jump) pend = 0;
            else if (pend > 0) pend--;
            else if (lu_model()) pend = lb - 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [6:0] ea, eb;
        @(negedge CLK);
        ea = exp_ctl(a_pend, a_hlt);
        eb = exp_ctl(b_pend, b_hlt);
        chk("a_ctl", {25'd0, a_pc, a_ife, a_ide, a_exe, a_mwe, a_iff, a_idf}, {25'd0, ea});
        chk("b_ctl", {25'd0, b_pc, b_ife, b_ide, b_exe, b_mwe, b_iff, b_idf}, {25'd0, eb});
        if (known) begin
            chk("a_halt",  {31'd0, a_halt}, {31'd0, a_hlt});
            chk("b_halt",  {31'd0, b_halt}, {31'd0, b_hlt});
            chk("a_stall", {16'd0, a_stall}, a_cnt);
            chk("b_stall", {24'd0, b_stall}, b_cnt);
        end
        @(posedge CLK);
        if (RST) known = 1;
        advance(1, 65535, ea, a_pend, a_hlt, a_cnt);
        advance(3, 255,   eb, b_pend, b_hlt, b_cnt);
        #1;
    endtask

    task automatic idle();
        RST = 0; ihit = 1; dhit = 1; ren = 0; wen = 0; branch = 0; jump = 0;
        halt_wb = 0; op_ex = RTYPE; rt_ex = 0; op_id = RTYPE; rs_id = 0; rt_id = 0;
    endtask

    initial begin
        int snap;
        logic [5:0] ops [7];
        ops = '{RTYPE, LW, LL, SW, SC, BEQ, ADDI};
        a_pend = 0; b_pend = 0; a_cnt = 0; b_cnt = 0; a_hlt = 0; b_hlt = 0;
        known = 0; b_bubbles = 0;
        idle();
        RST = 1;

        // reset
        cycle(); cycle();
        idle();
        chk("rst_halt_a",  {31'd0, a_halt}, 32'd0);
        chk("rst_stall_a", {16'd0, a_stall}, 32'd0);
        chk("rst_stall_b", {24'd0, b_stall}, 32'd0);

        // LW $5 in EX, ADD rs=$5 in ID: one bubble on the 1-bubble unit
        op_ex = LW; rt_ex = 5; op_id = RTYPE; rs_id = 5; rt_id = 9;
        cycle();
        idle();
        chk("lu_stall_cnt_a", {16'd0, a_stall}, 32'd1);
        repeat (4) cycle();

        // load into $0 is never a hazard
        snap = a_stall;
        op_ex = LW; rt_ex = 0; op_id = RTYPE; rs_id = 0; rt_id = 0;
        cycle();
        idle();
        chk("lu_zero_a", {16'd0, a_stall}, snap);

        // 3-bubble unit: dcache freeze in the middle of the load stall
        snap = b_bubbles;
        op_ex = LW; rt_ex = 7; op_id = BEQ; rs_id = 1; rt_id = 7;
        cycle();
        idle();
        cycle();
        ren = 1; dhit = 0;
        cycle(); cycle();
        dhit = 1;
        cycle();
        idle();
        cycle(); cycle();
        chk("lu3_bubbles_b", b_bubbles - snap, 32'd3);

        // redirect squashes a coincident load-use
        op_ex = LW; rt_ex = 5; op_id = RTYPE; rs_id = 5; branch = 1;
        cycle();
        idle();
        chk("redir_pend_b", b_pend, 32'd0);
        repeat (3) cycle();

        // halt, then reset
        halt_wb = 1;
        cycle();
        idle();
        repeat (3) cycle();
        chk("halt_sticky_a", {31'd0, a_halt}, 32'd1);
        RST = 1;
        cycle();
        idle();
        chk("halt_rst_a",  {31'd0, a_halt}, 32'd0);
        chk("stall_rst_b", {24'd0, b_stall}, 32'd0);

        // long fetch miss: narrow counter saturates
        ihit = 0;
        repeat (300) cycle();
        idle();
        chk("sat_b",  {24'd0, b_stall}, 32'd255);
        chk("wide_a", {16'd0, a_stall}, 32'd300);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            ihit    = ($urandom_range(0, 7) != 0);
            dhit    = ($urandom_range(0, 3) != 0);
            ren     = ($urandom_range(0, 3) == 0);
            wen     = ($urandom_range(0, 7) == 0);
            op_ex   = ops[$urandom_range(0, 6)];
            op_id   = ops[$urandom_range(0, 6)];
            rt_ex   = 5'($urandom_range(0, 3));
            rs_id   = 5'($urandom_range(0, 3));
            rt_id   = 5'($urandom_range(0, 3));
            branch  = ($urandom_range(0, 11) == 0);
            jump    = ($urandom_range(0, 15) == 0);
            halt_wb = ($urandom_range(0, 79) == 0);
            RST     = ($urandom_range(0, 99) == 0) || (a_hlt && $urandom_range(0, 3) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
